// File: rtl/tile_probe_reader_if.sv
// Probe request/result handshake plus pixel-store read port for tile_probe_reader.
// The master side is the game controller together with the pixel store; the slave side is the reader.
interface tile_probe_reader_if #(
    parameter int CW = 7
);
    logic          start;
    logic [7:0]    x_org;
    logic [6:0]    y_org;
    logic [2:0]    target_colour;
    logic          mem_rd;
    logic [7:0]    mem_x;
    logic [6:0]    mem_y;
    logic [2:0]    mem_data;
    logic          busy;
    logic          done;
    logic [CW-1:0] match_count;
    logic          hit;
    logic          oob;

    modport master (
        output start, x_org, y_org, target_colour, mem_data,
        input  mem_rd, mem_x, mem_y, busy, done, match_count, hit, oob
    );

    modport slave (
        input  start, x_org, y_org, target_colour, mem_data,
        output mem_rd, mem_x, mem_y, busy, done, match_count, hit, oob
    );
endinterface

// File: rtl/tile_probe_reader.sv
// Reads back one XDIM x YDIM block from the pixel store in row-major order and
// counts the in-bounds pixels that equal a target colour.
module tile_probe_reader #(
    parameter int XDIM    = 10,
    parameter int YDIM    = 10,
    parameter int XSCREEN = 160,
    parameter int YSCREEN = 120,
    parameter int CW      = 7
) (
    input  logic                clk,
    input  logic                reset,
    tile_probe_reader_if.slave  bus
);
    localparam int CXW = (XDIM > 1) ? $clog2(XDIM) : 1;
    localparam int CYW = (YDIM > 1) ? $clog2(YDIM) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [CXW-1:0] col_q, col_d;
    logic [CYW-1:0] row_q, row_d;
    logic [7:0]     xo_q, xo_d;
    logic [6:0]     yo_q, yo_d;
    logic [2:0]     tgt_q, tgt_d;
    logic           rd_q, rd_d;
    logic [7:0]     mx_q, mx_d;
    logic [6:0]     my_q, my_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           hit_q, hit_d;
    logic           oob_q, oob_d;
    logic           vld_q;

    logic [7:0]     base_x_s;
    logic [6:0]     base_y_s;
    logic [CXW-1:0] nxt_col_s;
    logic [CYW-1:0] nxt_row_s;
    logic [8:0]     sum_x_s;
    logic [7:0]     sum_y_s;
    logic           off_s;
    logic           last_s;
    logic           match_s;

    // Position of the pixel to issue next and its screen address; sums are one bit wider so they never wrap.
    always_comb begin
        if (state_q == S_IDLE) begin
            base_x_s  = bus.x_org;
            base_y_s  = bus.y_org;
            nxt_col_s = '0;
            nxt_row_s = '0;
        end else begin
            base_x_s = xo_q;
            base_y_s = yo_q;
            if (col_q == CXW'(XDIM - 1)) begin
                nxt_col_s = '0;
                nxt_row_s = row_q + CYW'(1);
            end else begin
                nxt_col_s = col_q + CXW'(1);
                nxt_row_s = row_q;
            end
        end
        sum_x_s = {1'b0, base_x_s} + 9'(nxt_col_s);
        sum_y_s = {1'b0, base_y_s} + 8'(nxt_row_s);
        off_s   = (sum_x_s >= 9'(XSCREEN)) || (sum_y_s >= 8'(YSCREEN));
        last_s  = (col_q == CXW'(XDIM - 1)) && (row_q == CYW'(YDIM - 1));
        match_s = vld_q && (bus.mem_data == tgt_q);
    end

    // Next-state and next-output logic for the probe sequencer.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        tgt_d   = tgt_q;
        rd_d    = 1'b0;
        mx_d    = mx_q;
        my_d    = my_q;
        oob_d   = oob_q;
        if (match_s) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_READ;
                    col_d   = nxt_col_s;
                    row_d   = nxt_row_s;
                    xo_d    = bus.x_org;
                    yo_d    = bus.y_org;
                    tgt_d   = bus.target_colour;
                    cnt_d   = '0;
                    oob_d   = off_s;
                    rd_d    = ~off_s;
                    if (!off_s) begin
                        mx_d = sum_x_s[7:0];
                        my_d = sum_y_s[6:0];
                    end else begin
                        mx_d = mx_q;
                        my_d = my_q;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (last_s) begin
                    state_d = S_DRAIN;
                end else begin
                    col_d = nxt_col_s;
                    row_d = nxt_row_s;
                    rd_d  = ~off_s;
                    oob_d = oob_q | off_s;
                    if (!off_s) begin
                        mx_d = sum_x_s[7:0];
                        my_d = sum_y_s[6:0];
                    end else begin
                        mx_d = mx_q;
                        my_d = my_q;
                    end
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        hit_d  = (cnt_d != '0);
    end

    // State and registered outputs; clearing vld_q on reset drops any read still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            xo_q    <= 8'd0;
            yo_q    <= 7'd0;
            tgt_q   <= 3'd0;
            rd_q    <= 1'b0;
            mx_q    <= 8'd0;
            my_q    <= 7'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            oob_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            tgt_q   <= tgt_d;
            rd_q    <= rd_d;
            mx_q    <= mx_d;
            my_q    <= my_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            oob_q   <= oob_d;
            vld_q   <= rd_q;
        end
    end

    assign bus.mem_rd      = rd_q;
    assign bus.mem_x       = mx_q;
    assign bus.mem_y       = my_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.match_count = cnt_q;
    assign bus.hit         = hit_q;
    assign bus.oob         = oob_q;
endmodule
